// File: rtl/gcd_lcm_pkg.sv
// Shared types and defaults for the GCD/LCM engine scheduler.
package gcd_lcm_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int ID_W_DEF    = 2;
  localparam int TIMEOUT_DEF = 320;
  localparam int CNT_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_KILL  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Response record, sized for the default operand and ID widths.
  typedef struct packed {
    logic [ID_W_DEF-1:0]     id;
    logic [2*DATA_W_DEF-1:0] lcm;
    logic [DATA_W_DEF-1:0]   gcd;
    logic                    err;
  } rsp_t;

endpackage

// File: rtl/gcd_lcm_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last+1, wrapping modulo N.
module rr_arbiter
  import gcd_lcm_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic w_found;
  int   w_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(last) + k) % N;
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/gcd_lcm_sched.sv
// Shares one iterative GCD/LCM engine between N_REQ requesters, one job in flight,
// with a zero-operand bypass and a watchdog that kills a stuck engine.
module gcd_lcm_sched
  import gcd_lcm_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_REQ   = 4,
  parameter int ID_W    = ID_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_vld,
  output logic [N_REQ-1:0]        req_rdy,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic                    rsp_vld,
  input  logic                    rsp_rdy,
  output logic [ID_W-1:0]         rsp_id,
  output logic [2*DATA_W-1:0]     rsp_lcm,
  output logic [DATA_W-1:0]       rsp_gcd,
  output logic                    rsp_err,
  output logic                    eng_vld_in,
  output logic [DATA_W-1:0]       eng_a,
  output logic [DATA_W-1:0]       eng_b,
  input  logic                    eng_vld_out,
  input  logic [2*DATA_W-1:0]     eng_lcm,
  input  logic [DATA_W-1:0]       eng_mcd,
  output logic                    eng_kill,
  output logic [2:0]              dbg_state
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are
  // both high; requesters hold valid and operands until accepted, and the
  // response fields stay stable while rsp_vld is high and rsp_rdy is low.

  state_e              r_state, w_state_nxt;
  logic [ID_W-1:0]     r_last;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_eng_a, r_eng_b;
  rsp_t                r_rsp;
  logic                r_eng_kill;

  logic [N_REQ-1:0]    w_gnt;
  logic [ID_W-1:0]     w_gnt_idx;
  logic [DATA_W-1:0]   w_sel_a, w_sel_b;
  logic                w_accept, w_zero, w_timeout;
  logic [CNT_W-1:0]    w_cnt_inc;

  rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_arb (
    .req     (req_vld),
    .last    (r_last),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_sel_a   = req_a[int'(w_gnt_idx)*DATA_W +: DATA_W];
  assign w_sel_b   = req_b[int'(w_gnt_idx)*DATA_W +: DATA_W];
  assign w_accept  = (r_state == ST_IDLE) && (|w_gnt);
  assign w_zero    = (w_sel_a == '0) || (w_sel_b == '0);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = w_zero ? ST_RESP : ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      // Done has priority over a timeout landing in the same cycle.
      ST_WAIT: begin
        if (eng_vld_out)    w_state_nxt = ST_RESP;
        else if (w_timeout) w_state_nxt = ST_KILL;
      end
      ST_KILL:  w_state_nxt = ST_RESP;
      ST_RESP:  if (rsp_rdy) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_rdy    = '0;
    if (r_state == ST_IDLE) req_rdy = w_gnt;
    rsp_vld    = (r_state == ST_RESP);
    eng_vld_in = (r_state == ST_ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= ID_W'(N_REQ - 1);
      r_cnt      <= '0;
      r_eng_a    <= '0;
      r_eng_b    <= '0;
      r_rsp      <= '0;
      r_eng_kill <= 1'b0;
    end else begin
      r_eng_kill <= (r_state == ST_WAIT) && !eng_vld_out && w_timeout;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_last   <= w_gnt_idx;
            r_rsp.id <= w_gnt_idx;
            // Zero operands never terminate in the engine, so answer directly.
            if (w_zero) begin
              r_rsp.lcm <= '0;
              r_rsp.gcd <= w_sel_a | w_sel_b;
              r_rsp.err <= 1'b0;
            end else begin
              r_eng_a <= w_sel_a;
              r_eng_b <= w_sel_b;
            end
          end
        end
        ST_ISSUE: r_cnt <= '0;
        ST_WAIT: begin
          if (eng_vld_out) begin
            r_rsp.lcm <= eng_lcm;
            r_rsp.gcd <= eng_mcd;
            r_rsp.err <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) begin
              r_rsp.lcm <= '0;
              r_rsp.gcd <= '0;
              r_rsp.err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign eng_a     = r_eng_a;
  assign eng_b     = r_eng_b;
  assign eng_kill  = r_eng_kill;
  assign rsp_id    = r_rsp.id;
  assign rsp_lcm   = r_rsp.lcm;
  assign rsp_gcd   = r_rsp.gcd;
  assign rsp_err   = r_rsp.err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_gcd_lcm_sched.sv
// Bench for gcd_lcm_sched: behavioural engine, round-robin/response model and scoreboard.
module tb_gcd_lcm_sched;

  localparam int DW   = 8;
  localparam int NR   = 4;
  localparam int IW   = 2;
  localparam int TO   = 320;
  localparam int RW   = IW + 2*DW + DW + 1;
  localparam int NONE = -1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NR-1:0]    job_vld;
  logic [DW-1:0]    job_a [NR];
  logic [DW-1:0]    job_b [NR];
  logic [NR-1:0]    req_rdy;
  logic [NR*DW-1:0] req_a, req_b;
  logic             rsp_vld, rsp_rdy, rsp_err;
  logic [IW-1:0]    rsp_id;
  logic [2*DW-1:0]  rsp_lcm;
  logic [DW-1:0]    rsp_gcd;
  logic             eng_vld_in, eng_vld_out, eng_kill;
  logic [DW-1:0]    eng_a, eng_b;
  logic [2*DW-1:0]  eng_lcm = '0;
  logic [DW-1:0]    eng_mcd = '0;
  logic [2:0]       dbg_state;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = job_a[i];
      req_b[i*DW +: DW] = job_b[i];
    end
  end

  gcd_lcm_sched #(.DATA_W(DW), .N_REQ(NR), .ID_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(job_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_lcm(rsp_lcm),
    .rsp_gcd(rsp_gcd), .rsp_err(rsp_err),
    .eng_vld_in(eng_vld_in), .eng_a(eng_a), .eng_b(eng_b),
    .eng_vld_out(eng_vld_out), .eng_lcm(eng_lcm), .eng_mcd(eng_mcd),
    .eng_kill(eng_kill), .dbg_state(dbg_state)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic [DW-1:0] ref_gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return DW'(x);
  endfunction

  function automatic logic [2*DW-1:0] ref_lcm(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int g;
    g = int'(ref_gcd(a, b));
    if (g == 0) return '0;
    return (2*DW)'((int'(a) * int'(b)) / g);
  endfunction

  function automatic logic [RW-1:0] exp_rsp(input int id, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic err);
    if (a == 0 || b == 0) return {IW'(id), (2*DW)'(0), a | b, 1'b0};
    if (err)              return {IW'(id), (2*DW)'(0), DW'(0), 1'b1};
    return {IW'(id), ref_lcm(a, b), ref_gcd(a, b), 1'b0};
  endfunction

  // ---------------- engine model ----------------
  logic       eng_rst_n, e_busy, e_done, spur, eng_hang;
  logic [9:0] e_cnt, eng_lat;
  logic [DW-1:0] e_a, e_b;
  assign eng_rst_n   = rst_n & ~eng_kill;
  assign eng_vld_out = e_done | spur;

  always @(posedge clk or negedge eng_rst_n) begin
    if (!eng_rst_n) begin
      e_busy <= 1'b0;
      e_done <= 1'b0;
      e_cnt  <= '0;
      e_a    <= '0;
      e_b    <= '0;
    end else begin
      e_done <= 1'b0;
      if (eng_vld_in) begin
        e_busy <= 1'b1;
        e_cnt  <= eng_lat;
        e_a    <= eng_a;
        e_b    <= eng_b;
      end else if (e_busy && !eng_hang) begin
        if (e_cnt == 0) begin
          e_done  <= 1'b1;
          e_busy  <= 1'b0;
          eng_lcm <= ref_lcm(e_a, e_b);
          eng_mcd <= ref_gcd(e_a, e_b);
        end else begin
          e_cnt <= e_cnt - 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard / model state ----------------
  logic [RW-1:0] exp_q[$];
  int n_chk = 0, n_pass = 0, cyc = 0;
  int m_last, m_issue_due, m_kill_due, m_rsp_due;
  logic [DW-1:0] m_ea, m_eb;
  logic prev_rsp_vld, rdy_rand, rand_lat;
  int refill_cnt, clr_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int model_grant();
    for (int k = 1; k <= NR; k++) begin
      if (job_vld[(m_last + k) % NR]) return (m_last + k) % NR;
    end
    return NONE;
  endfunction

  // Observes the edge that is about to happen and checks it against the model.
  task automatic monitor();
    int g, obs_idx;
    logic zero, err;
    obs_idx = NONE;
    for (int i = 0; i < NR; i++) if (job_vld[i] && req_rdy[i]) obs_idx = i;
    if (obs_idx != NONE) begin
      check("rdy_onehot", $countones(req_rdy), 1);
      g = model_grant();
      check("grant_id", obs_idx, g);
      m_last  = g;
      clr_idx = g;
      if (rand_lat) eng_lat = 10'($urandom_range(0, 6));
      zero = (job_a[g] == 0) || (job_b[g] == 0);
      err  = !zero && (eng_hang || int'(eng_lat) > TO - 2);
      exp_q.push_back(exp_rsp(g, job_a[g], job_b[g], err));
      m_ea        = job_a[g];
      m_eb        = job_b[g];
      m_issue_due = zero ? NONE : cyc + 1;
      m_kill_due  = err ? cyc + TO + 2 : NONE;
      m_rsp_due   = zero ? cyc + 1 : (err ? cyc + TO + 3 : cyc + 4 + int'(eng_lat));
    end
    if (eng_vld_in) begin
      check("issue_cyc", cyc, m_issue_due);
      check("eng_a", eng_a, m_ea);
      check("eng_b", eng_b, m_eb);
    end
    if (eng_kill) check("kill_cyc", cyc, m_kill_due);
    if (rsp_vld && !prev_rsp_vld) check("rsp_cyc", cyc, m_rsp_due);
    if (rsp_vld) begin
      if (exp_q.size() == 0) check("rsp_unexpected", rsp_vld, 0);
      else begin
        check("rsp_fields", {rsp_id, rsp_lcm, rsp_gcd, rsp_err}, exp_q[0]);
        if (rsp_rdy) void'(exp_q.pop_front());
      end
    end
    prev_rsp_vld = rsp_vld;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk);
    clr_idx = NONE;
    if (rst_n) monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (clr_idx != NONE) begin
      if (refill_cnt > 0) refill_cnt--;
      else job_vld[clr_idx] = 1'b0;
    end
    spur = 1'b0;
    if (rdy_rand) rsp_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input int id, input int a, input int b);
    job_a[id]   = DW'(a);
    job_b[id]   = DW'(b);
    job_vld[id] = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((job_vld != 0 || exp_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_bound", exp_q.size() + $countones(job_vld), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rsp_vld"}, rsp_vld, 0);
    check({tag, "_eng_vld_in"}, eng_vld_in, 0);
    check({tag, "_eng_kill"}, eng_kill, 0);
    check({tag, "_eng_ab"}, {eng_a, eng_b}, 0);
    check({tag, "_rsp_data"}, {rsp_id, rsp_lcm, rsp_gcd, rsp_err}, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; job_vld = '0; rsp_rdy = 1'b1; rdy_rand = 1'b0; rand_lat = 1'b0;
    eng_hang = 1'b0; eng_lat = 10'd2; spur = 1'b0; refill_cnt = 0; clr_idx = NONE;
    prev_rsp_vld = 1'b0; m_last = NR - 1; m_issue_due = NONE; m_kill_due = NONE;
    m_rsp_due = NONE; m_ea = '0; m_eb = '0;
    for (int i = 0; i < NR; i++) begin job_a[i] = '0; job_b[i] = '0; end

    repeat (3) cycle();
    check_outputs_zero("reset");
    check("reset_req_rdy", req_rdy, 0);
    rst_n = 1'b1;
    cycle();

    // single job
    push(0, 12, 18);
    drain(50);

    // fairness with all requesters continuously valid
    for (int i = 0; i < NR; i++) push(i, 4, 6);
    refill_cnt = 4;
    drain(200);

    // zero-operand bypass
    push(2, 0, 9);  drain(20);
    push(1, 0, 0);  drain(20);
    push(3, 7, 0);  drain(20);

    // watchdog, then a normal job
    eng_hang = 1'b1;
    push(1, 30, 12); drain(400);
    eng_hang = 1'b0;
    push(1, 30, 12); drain(50);

    // done on the last WAIT cycle beats the timeout
    eng_lat = 10'(TO - 2);
    push(2, 200, 150); drain(400);
    eng_lat = 10'd2;

    // backpressure with a spurious done in RESP
    rsp_rdy = 1'b0;
    push(3, 9, 6);
    repeat (6) cycle();
    spur = 1'b1;
    repeat (10) cycle();
    rsp_rdy = 1'b1;
    drain(20);

    // spurious done in IDLE
    spur = 1'b1;
    repeat (3) cycle();
    check("spur_idle_state", dbg_state, 0);

    // randomized traffic
    rdy_rand = 1'b1; rand_lat = 1'b1;
    for (int n = 0; n < 80; n++) begin
      int id;
      id = int'($urandom_range(0, NR - 1));
      if (!job_vld[id]) begin
        push(id, ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255)),
                 ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255)));
      end
      cycle();
    end
    drain(3000);
    rdy_rand = 1'b0; rand_lat = 1'b0; rsp_rdy = 1'b1; eng_lat = 10'd2;

    // reset while the engine is busy
    eng_hang = 1'b1;
    push(1, 10, 4);
    repeat (4) cycle();
    check("mid_wait_state", dbg_state, 2);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    m_last = NR - 1; prev_rsp_vld = 1'b0; eng_hang = 1'b0;
    m_issue_due = NONE; m_kill_due = NONE; m_rsp_due = NONE;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    push(2, 5, 10);
    push(0, 8, 12);
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
